// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ==========================================================================
// Module  : ps2_host_tx_if
// Purpose : Command handshake between a requester and the PS/2 transmitter.
// Revision: 1.0
// ==========================================================================
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_err;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx_busy, tx_done, tx_err
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx_busy, tx_done, tx_err
   );
endinterface
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ==========================================================================
// Module  : ps2_host_tx
// Purpose : PS/2 host-to-device command byte transmitter (open-drain lines).
// Option  : define PS2_TX_RETRY_EN for up to two automatic retries.
// Revision: 1.0
// ==========================================================================
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 1500000,
   parameter int FILTER_LEN     = 8
) (
   input  wire logic    clk,
   input  wire logic    reset,
   ps2_host_tx_if.slave tx,
   input  wire logic    ps2_clk_in,
   input  wire logic    ps2_data_in,
   output logic         ps2_clk_oe,
   output logic         ps2_data_oe
);

   localparam int c_inh_w = $clog2(INHIBIT_CYCLES + 1);
   localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
   localparam int c_flt_w = $clog2(FILTER_LEN + 1);
   localparam logic [c_inh_w-1:0] c_inh_last = c_inh_w'(INHIBIT_CYCLES - 1);
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
   localparam logic [c_flt_w-1:0] c_flt_last = c_flt_w'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_SEND      = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5,
      ST_DONE      = 3'd6,
      ST_ERR       = 3'd7
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:0]         r_clk_sync;
   logic [1:0]         r_data_sync;
   logic               r_clk_filt;
   logic               r_clk_filt_d;
   logic [c_flt_w-1:0] r_flt_cnt;
   logic [c_inh_w-1:0] r_inh_cnt;
   logic [c_tmo_w-1:0] r_tmo_cnt;
   logic [7:0]         r_byte;
   logic [9:0]         r_shift;
   logic [3:0]         r_bit_cnt;
   logic               r_drive;
   logic               w_clk_s;
   logic               w_data_s;
   logic               w_fall;
   logic               w_timeout;
   logic               w_fail;
   logic               w_retry_left;
   logic               w_clk_oe;
   logic               w_data_oe;
   logic               w_running;

   // Both pads are idle-high (pulled up), so synchronisers reset to 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_clk_sync  <= 2'b11;
         r_data_sync <= 2'b11;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
         r_data_sync <= {r_data_sync[0], ps2_data_in};
      end
   end

   assign w_clk_s  = r_clk_sync[1];
   assign w_data_s = r_data_sync[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_clk_filt   <= 1'b1;
         r_clk_filt_d <= 1'b1;
         r_flt_cnt    <= '0;
      end else begin
         r_clk_filt_d <= r_clk_filt;
         if (w_clk_s == r_clk_filt) begin
            r_flt_cnt <= '0;
         end else if (r_flt_cnt == c_flt_last) begin
            r_clk_filt <= w_clk_s;
            r_flt_cnt  <= '0;
         end else begin
            r_flt_cnt <= r_flt_cnt + c_flt_w'(1);
         end
      end
   end

   assign w_fall    = r_clk_filt_d & ~r_clk_filt;
   assign w_timeout = (r_tmo_cnt == c_tmo_last);
   assign w_running = (r_state == ST_REQ) || (r_state == ST_SEND) ||
                      (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);

`ifdef PS2_TX_RETRY_EN
   logic [1:0] r_retry_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_retry_cnt <= 2'd0;
      end else if (r_state == ST_IDLE) begin
         r_retry_cnt <= 2'd0;
      end else if (w_fail) begin
         r_retry_cnt <= r_retry_cnt + 2'd1;
      end
   end

   assign w_retry_left = (r_retry_cnt != 2'd2);
`else
   assign w_retry_left = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clk_oe    = 1'b0;
      w_data_oe   = 1'b0;
      w_fail      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (tx.tx_valid) begin
               w_state_nxt = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            w_clk_oe = 1'b1;
            if (r_inh_cnt == c_inh_last) begin
               w_data_oe   = 1'b1;
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            w_data_oe = 1'b1;
            if (w_timeout) begin
               w_fail = 1'b1;
            end else begin
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            w_data_oe = r_drive;
            if (w_timeout) begin
               w_fail = 1'b1;
            end else if (w_fall && (r_bit_cnt == 4'd9)) begin
               w_state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            w_data_oe = r_drive;
            if (w_timeout) begin
               w_fail = 1'b1;
            end else if (w_fall) begin
               if (w_data_s) begin
                  w_fail = 1'b1;
               end else begin
                  w_state_nxt = ST_WAIT_IDLE;
               end
            end
         end
         ST_WAIT_IDLE: begin
            if (w_timeout) begin
               w_fail = 1'b1;
            end else if (w_clk_s && w_data_s) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         ST_ERR: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (w_fail) begin
         w_state_nxt = w_retry_left ? ST_INHIBIT : ST_ERR;
      end
   end

   // Frame is reloaded from the latched byte on every REQ so retries resend it intact.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_inh_cnt <= '0;
         r_tmo_cnt <= '0;
         r_byte    <= '0;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_drive   <= 1'b0;
      end else begin
         if (r_state == ST_INHIBIT) begin
            r_inh_cnt <= r_inh_cnt + c_inh_w'(1);
         end else begin
            r_inh_cnt <= '0;
         end

         if (w_running && !w_fail) begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
         end else begin
            r_tmo_cnt <= '0;
         end

         if ((r_state == ST_IDLE) && tx.tx_valid) begin
            r_byte <= tx.tx_data;
         end

         if (r_state == ST_REQ) begin
            r_shift   <= {1'b1, ~^r_byte, r_byte};
            r_bit_cnt <= '0;
            r_drive   <= 1'b1;
         end else if ((r_state == ST_SEND) && w_fall) begin
            r_drive   <= ~r_shift[0];
            r_shift   <= {1'b0, r_shift[9:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end
      end
   end

   assign ps2_clk_oe  = w_clk_oe;
   assign ps2_data_oe = w_data_oe;
   assign tx.tx_ready = (r_state == ST_IDLE);
   assign tx.tx_busy  = (r_state != ST_IDLE);
   assign tx.tx_done  = (r_state == ST_DONE);
   assign tx.tx_err   = (r_state == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ==========================================================================
// Module  : tb_ps2_host_tx
// Purpose : Directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Revision: 1.0
// ==========================================================================
module tb_ps2_host_tx;

   localparam int INH  = 200;
   localparam int TMO  = 3000;
   localparam int FLT  = 8;
   localparam int HALF = 40;
`ifdef PS2_TX_RETRY_EN
   localparam int ATTEMPTS = 3;
`else
   localparam int ATTEMPTS = 1;
`endif

   logic clk;
   logic reset;
   logic dev_clk_low;
   logic dev_data_low;
   wire logic ps2_clk_in;
   wire logic ps2_data_in;
   wire logic ps2_clk_oe;
   wire logic ps2_data_oe;

   int n_checks;
   int n_fail;
   int done_cnt;
   int err_cnt;
   int inh_run;
   int inh_phases;
   int last_inh_len;
   int dev_clk_cnt;

   ps2_host_tx_if tif();

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO),
      .FILTER_LEN     (FLT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tx          (tif),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   // Wired-AND open-drain lines with pull-ups.
   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tif.tx_done) done_cnt <= done_cnt + 1;
      if (tif.tx_err)  err_cnt  <= err_cnt + 1;
      if (ps2_clk_oe) begin
         inh_run <= inh_run + 1;
      end else if (inh_run != 0) begin
         last_inh_len <= inh_run;
         inh_phases   <= inh_phases + 1;
         inh_run      <= 0;
      end
   end

   task automatic send_req(input logic [7:0] b);
      tif.tx_data  = b;
      tif.tx_valid = 1'b1;
      @(negedge clk);
      tif.tx_valid = 1'b0;
   endtask

   // Device: waits for host release with start bit, clocks 11 times, samples on rising edges.
   task automatic dev_run(input bit ack, input bit glitch, output logic [9:0] bits);
      int t;
      bits = '0;
      dev_clk_cnt = 0;
      t = 0;
      while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && t < 2*INH + 200) begin
         @(negedge clk);
         t++;
      end
      if (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0)) begin
         n_checks++;
         n_fail++;
         $display("FAIL dev_start_wait: no release with start bit after %0d cycles, required within %0d", t, 2*INH + 200);
      end else begin
         repeat (30) @(negedge clk);
         for (int i = 1; i <= 11; i++) begin
            dev_clk_cnt = i;
            if (i == 11) dev_data_low = ack;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i <= 10) bits[i-1] = ps2_data_in;
            if (i == 11) dev_data_low = 1'b0;
            if (glitch && i >= 2 && i <= 9) begin
               repeat (10) @(negedge clk);
               dev_clk_low = 1'b1;
               repeat (3) @(negedge clk);
               dev_clk_low = 1'b0;
               repeat (HALF - 13) @(negedge clk);
            end else begin
               repeat (HALF) @(negedge clk);
            end
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (tif.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", tif.tx_ready); end
      n_checks++;
      if (tif.tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", tif.tx_busy); end
      n_checks++;
      if (tif.tx_done !== 1'b0 || tif.tx_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_pulses: got done=%b err=%b expected 0/0", tif.tx_done, tif.tx_err);
      end
      n_checks++;
      if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
         n_fail++; $display("FAIL reset_oe: got clk_oe=%b data_oe=%b expected 0/0", ps2_clk_oe, ps2_data_oe);
      end
      reset = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_send(input logic [7:0] b, input logic [9:0] exp_bits, input bit glitch);
      int d0, e0, p0;
      logic [9:0] bits;
      d0 = done_cnt; e0 = err_cnt; p0 = inh_phases;
      send_req(b);
      n_checks++;
      if (ps2_clk_oe !== 1'b1 || tif.tx_busy !== 1'b1) begin
         n_fail++; $display("FAIL send_%h_latency: got clk_oe=%b busy=%b expected 1/1", b, ps2_clk_oe, tif.tx_busy);
      end
      dev_run(1'b1, glitch, bits);
      repeat (20) @(negedge clk);
      n_checks++;
      if (bits !== exp_bits) begin n_fail++; $display("FAIL send_%h_bits: got %b expected %b", b, bits, exp_bits); end
      n_checks++;
      if (inh_phases - p0 !== 1 || last_inh_len !== INH) begin
         n_fail++; $display("FAIL send_%h_inhibit: got %0d phases of %0d cycles expected 1 of %0d", b, inh_phases - p0, last_inh_len, INH);
      end
      n_checks++;
      if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL send_%h_done: got %0d pulses expected 1", b, done_cnt - d0); end
      n_checks++;
      if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL send_%h_err: got %0d pulses expected 0", b, err_cnt - e0); end
      n_checks++;
      if (tif.tx_ready !== 1'b1 || ps2_data_oe !== 1'b0) begin
         n_fail++; $display("FAIL send_%h_idle: got ready=%b data_oe=%b expected 1/0", b, tif.tx_ready, ps2_data_oe);
      end
   endtask

   task automatic test_timeout;
      int t, n, exp_n;
      exp_n = ATTEMPTS * TMO + (ATTEMPTS - 1) * INH;
      send_req(8'hF4);
      t = 0;
      while (ps2_clk_oe === 1'b1 && t < INH + 50) begin @(negedge clk); t++; end
      n = 0;
      while (tif.tx_err !== 1'b1 && n < exp_n + 100) begin @(negedge clk); n++; end
      n_checks++;
      if (n !== exp_n) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected %0d", n, exp_n); end
      n_checks++;
      if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
         n_fail++; $display("FAIL timeout_oe: got clk_oe=%b data_oe=%b expected 0/0", ps2_clk_oe, ps2_data_oe);
      end
      @(negedge clk);
      n_checks++;
      if (tif.tx_ready !== 1'b1 || tif.tx_err !== 1'b0) begin
         n_fail++; $display("FAIL timeout_after: got ready=%b err=%b expected 1/0", tif.tx_ready, tif.tx_err);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_no_ack;
      int d0, e0, p0;
      logic [9:0] bits;
      d0 = done_cnt; e0 = err_cnt; p0 = inh_phases;
      send_req(8'hF4);
      for (int k = 0; k < ATTEMPTS; k++) begin
         dev_run(1'b0, 1'b0, bits);
         n_checks++;
         if (bits !== 10'b1_0_11110100) begin n_fail++; $display("FAIL noack_bits_%0d: got %b expected %b", k, bits, 10'b1_0_11110100); end
         if (k < ATTEMPTS - 1) begin
            n_checks++;
            if (tif.tx_busy !== 1'b1 || err_cnt - e0 !== 0) begin
               n_fail++; $display("FAIL noack_retry_%0d: got busy=%b errs=%0d expected 1/0", k, tif.tx_busy, err_cnt - e0);
            end
         end
      end
      repeat (20) @(negedge clk);
      n_checks++;
      if (inh_phases - p0 !== ATTEMPTS) begin n_fail++; $display("FAIL noack_inhibits: got %0d expected %0d", inh_phases - p0, ATTEMPTS); end
      n_checks++;
      if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL noack_err: got %0d pulses expected 1", err_cnt - e0); end
      n_checks++;
      if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL noack_done: got %0d pulses expected 0", done_cnt - d0); end
      n_checks++;
      if (tif.tx_ready !== 1'b1) begin n_fail++; $display("FAIL noack_ready: got %b expected 1", tif.tx_ready); end
   endtask

   task automatic test_reset_midframe;
      int d0, e0, t;
      logic [9:0] bits;
      d0 = done_cnt; e0 = err_cnt;
      send_req(8'hF4);
      fork
         dev_run(1'b1, 1'b0, bits);
         begin
            t = 0;
            while (dev_clk_cnt < 4 && t < 5000) begin @(negedge clk); t++; end
            repeat (20) @(negedge clk);
            n_checks++;
            if (ps2_data_oe !== 1'b1) begin n_fail++; $display("FAIL midframe_bit4: got data_oe=%b expected 1", ps2_data_oe); end
            reset = 1'b0;
            #1;
            n_checks++;
            if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tif.tx_ready !== 1'b1) begin
               n_fail++; $display("FAIL midframe_async: got clk_oe=%b data_oe=%b ready=%b expected 0/0/1", ps2_clk_oe, ps2_data_oe, tif.tx_ready);
            end
            @(negedge clk);
            reset = 1'b1;
         end
      join
      repeat (20) @(negedge clk);
      n_checks++;
      if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
         n_fail++; $display("FAIL midframe_pulses: got done=%0d err=%0d expected 0/0", done_cnt - d0, err_cnt - e0);
      end
      n_checks++;
      if (tif.tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
         n_fail++; $display("FAIL midframe_idle: got ready=%b clk_oe=%b data_oe=%b expected 1/0/0", tif.tx_ready, ps2_clk_oe, ps2_data_oe);
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      done_cnt = 0; err_cnt = 0;
      inh_run = 0; inh_phases = 0; last_inh_len = 0; dev_clk_cnt = 0;
      dev_clk_low = 1'b0; dev_data_low = 1'b0;
      tif.tx_data = 8'h00; tif.tx_valid = 1'b0;
      reset = 1'b0;

      test_reset();
      test_send(8'hF4, 10'b1_0_11110100, 1'b0);
      test_send(8'hFF, 10'b1_1_11111111, 1'b0);
      test_timeout();
      test_no_ack();
      test_send(8'h5A, 10'b1_1_01011010, 1'b1);
      test_reset_midframe();
      test_send(8'hF4, 10'b1_0_11110100, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
